// File: rtl/cell_board_engine.sv
// cell_board_engine: Life-game cell grid with a combinational display read port,
// cursor toggles in edit mode, and a one-cell-per-cycle generation sweep into a
// shadow buffer followed by a buffer swap.
// Optional macro BOARD_WRAP_EN: toroidal neighbourhood. Default: cells off the
// board count as dead.
// MODE_EDIT: the mode input value that selects edit mode (default 1'b1).
`timescale 1ns/10ps

`ifndef MODE_EDIT
`define MODE_EDIT 1'b1
`endif

module cell_board_engine #(
    parameter int K     = 6,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [K-1:0]     rd_x,
    input  logic [K-1:0]     rd_y,
    output logic             rd_state,
    input  logic [K-1:0]     cur_x,
    input  logic [K-1:0]     cur_y,
    input  logic             toggle,
    input  logic             step_req,
    input  logic             clr,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count
);

    localparam int N  = 1 << K;
    localparam int NN = N * N;
    localparam int IW = 2 * K;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SWAP
    } state_t;

    // Buffers are flat vectors: the display read and the nine-cell neighbourhood
    // fetch all need simultaneous random access, which rules out block RAM.
    logic [NN-1:0]    r_buf_a;
    logic [NN-1:0]    r_buf_b;
    logic             r_front;       // 0: A is displayed, 1: B is displayed
    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic             r_busy;
    logic             r_done;
    logic [GEN_W-1:0] r_gen;

    logic [NN-1:0]    w_front;
    logic [K-1:0]     w_cx;
    logic [K-1:0]     w_cy;
    logic [8:0]       w_nb;
    logic [3:0]       w_cnt;
    logic             w_alive;
    logic             w_next;

    // Select the displayed buffer; both the display and the sweep read only this one.
    always_comb begin
        w_front = r_front ? r_buf_b : r_buf_a;
    end

    assign rd_state  = w_front[{rd_y, rd_x}];
    assign busy      = r_busy;
    assign done      = r_done;
    assign gen_count = r_gen;

    assign w_cx = r_idx[K-1:0];
    assign w_cy = r_idx[IW-1:K];

    // 3x3 window around the sweep cell; position 4 is the cell itself and is excluded.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_nb
            localparam int DX = (gi % 3) - 1;
            localparam int DY = (gi / 3) - 1;
            logic [K-1:0] w_nx;
            logic [K-1:0] w_ny;
            logic         w_in;

            // K-bit addition wraps modulo N for free.
            assign w_nx = w_cx + K'(DX);
            assign w_ny = w_cy + K'(DY);

`ifdef BOARD_WRAP_EN
            assign w_in = 1'b1;
`else
            // Reject neighbours whose coordinate wrapped off an edge.
            assign w_in = ((DX >= 0) || (w_cx != {K{1'b0}})) &&
                          ((DX <= 0) || (w_cx != {K{1'b1}})) &&
                          ((DY >= 0) || (w_cy != {K{1'b0}})) &&
                          ((DY <= 0) || (w_cy != {K{1'b1}}));
`endif

            assign w_nb[gi] = (gi != 4) && w_in && w_front[{w_ny, w_nx}];
        end
    endgenerate

    // Count live neighbours and apply the Life rule to the sweep cell.
    always_comb begin
        w_cnt = 4'd0;
        for (int i = 0; i < 9; i++) begin
            w_cnt = w_cnt + {3'b000, w_nb[i]};
        end
        w_alive = w_front[r_idx];
        w_next  = (w_cnt == 4'd3) | (w_alive & (w_cnt == 4'd2));
    end

    // Control FSM plus buffer writes: toggles hit the front buffer, the sweep fills the back one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_a <= '0;
            r_buf_b <= '0;
            r_front <= 1'b0;
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gen   <= '0;
        end else if (clr) begin
            // Clearing both buffers keeps the front all-dead whichever one is selected.
            r_buf_a <= '0;
            r_buf_b <= '0;
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gen   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mode != `MODE_EDIT) begin
                        if (step_req) begin
                            r_state <= S_SCAN;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end else if (toggle) begin
                        if (r_front)
                            r_buf_b[{cur_y, cur_x}] <= ~r_buf_b[{cur_y, cur_x}];
                        else
                            r_buf_a[{cur_y, cur_x}] <= ~r_buf_a[{cur_y, cur_x}];
                    end
                end
                S_SCAN: begin
                    if (r_front)
                        r_buf_a[r_idx] <= w_next;
                    else
                        r_buf_b[r_idx] <= w_next;
                    // Index rolls over to zero after the last cell, ready for the next step.
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == {IW{1'b1}})
                        r_state <= S_SWAP;
                end
                S_SWAP: begin
                    r_front <= ~r_front;
                    r_gen   <= r_gen + 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_board_engine.sv
// Directed testbench for cell_board_engine (K=6, 64x64 board).
// Expectations for the wrap scenario follow BOARD_WRAP_EN if it is defined.
`timescale 1ns/10ps

`ifndef MODE_EDIT
`define MODE_EDIT 1'b1
`endif

module tb_cell_board_engine;

    localparam int K        = 6;
    localparam int GW       = 16;
    localparam int N        = 1 << K;
    localparam int NN       = N * N;
    localparam int STEP_CYC = NN + 1;
    localparam logic EDIT   = `MODE_EDIT;
    localparam logic RUN    = ~EDIT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = EDIT;
    logic [K-1:0]  rd_x = '0;
    logic [K-1:0]  rd_y = '0;
    logic          rd_state;
    logic [K-1:0]  cur_x = '0;
    logic [K-1:0]  cur_y = '0;
    logic          toggle = 1'b0;
    logic          step_req = 1'b0;
    logic          clr = 1'b0;
    logic          busy;
    logic          done;
    logic [GW-1:0] gen_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cell_board_engine #(.K(K), .GEN_W(GW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_state  (rd_state),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .toggle    (toggle),
        .step_req  (step_req),
        .clr       (clr),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-24s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe(input int x, input int y, output logic v);
        rd_x = K'(x);
        rd_y = K'(y);
        #0.01;
        v = rd_state;
    endtask

    task automatic chk_cell(input string tag, input int x, input int y, input logic exp);
        logic v;
        probe(x, y, v);
        chk(tag, {31'd0, v}, {31'd0, exp});
    endtask

    // Count live cells over the whole board and in column x=0.
    task automatic scan(output int cnt, output int col0);
        logic v;
        cnt  = 0;
        col0 = 0;
        for (int y = 0; y < N; y++) begin
            for (int x = 0; x < N; x++) begin
                probe(x, y, v);
                if (v === 1'b1) begin
                    cnt++;
                    if (x == 0) col0++;
                end
            end
        end
        tick(1);
    endtask

    task automatic toggle_at(input int x, input int y);
        mode   = EDIT;
        cur_x  = K'(x);
        cur_y  = K'(y);
        toggle = 1'b1;
        tick(1);
        toggle = 1'b0;
    endtask

    // One generation; if inj >= 0, pulse toggle(3,3) and step_req in edit mode on that busy cycle.
    task automatic run_step(input string tag, input int inj);
        int cyc;
        mode     = RUN;
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < STEP_CYC + 10) begin
            if (cyc == inj) begin
                mode     = EDIT;
                cur_x    = K'(3);
                cur_y    = K'(3);
                toggle   = 1'b1;
                step_req = 1'b1;
            end
            cyc++;
            tick(1);
            toggle   = 1'b0;
            step_req = 1'b0;
            mode     = RUN;
        end
        chk({tag, "_busy_cyc"}, cyc, STEP_CYC);
        chk({tag, "_done_hi"}, {31'd0, done}, 32'd1);
        tick(1);
        chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cnt;
        int col0;
        int dones;

        // Reset state
        tick(3);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_gen", {16'd0, gen_count}, 32'd0);
        rst = 1'b0;
        tick(1);
        chk_cell("rst_cell_0_0", 0, 0, 1'b0);
        tick(1);

        // Blinker: toggle becomes visible in the cycle after the accepting edge
        toggle_at(10, 9);
        toggle_at(10, 10);
        chk_cell("toggle_latency", 10, 10, 1'b1);
        toggle_at(10, 11);
        run_step("blink1", -1);
        chk("blink1_gen", {16'd0, gen_count}, 32'd1);
        scan(cnt, col0);
        chk("blink1_count", cnt, 3);
        chk_cell("blink1_9_10", 9, 10, 1'b1);
        chk_cell("blink1_10_10", 10, 10, 1'b1);
        chk_cell("blink1_11_10", 11, 10, 1'b1);
        run_step("blink2", -1);
        chk("blink2_gen", {16'd0, gen_count}, 32'd2);
        scan(cnt, col0);
        chk("blink2_count", cnt, 3);
        chk_cell("blink2_10_9", 10, 9, 1'b1);
        chk_cell("blink2_10_11", 10, 11, 1'b1);
        tick(1);

        // step_req in edit mode is ignored
        mode     = EDIT;
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        chk("edit_step_busy", {31'd0, busy}, 32'd0);
        tick(2);
        chk("edit_step_busy2", {31'd0, busy}, 32'd0);
        chk("edit_step_gen", {16'd0, gen_count}, 32'd2);

        // toggle and step_req during SCAN are dropped
        run_step("inj", 200);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) dones++;
            tick(1);
        end
        chk("inj_extra_done", dones, 0);
        chk("inj_gen", {16'd0, gen_count}, 32'd3);
        scan(cnt, col0);
        chk("inj_count", cnt, 3);
        chk_cell("inj_cell_3_3", 3, 3, 1'b0);
        chk_cell("inj_9_10", 9, 10, 1'b1);
        tick(1);

        // Reset mid-SCAN
        mode     = RUN;
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(50);
        rst = 1'b1;
        tick(1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_gen", {16'd0, gen_count}, 32'd0);
        chk_cell("midrst_0_0", 0, 0, 1'b0);
        chk_cell("midrst_5_7", 5, 7, 1'b0);
        chk_cell("midrst_63_63", N - 1, N - 1, 1'b0);
        rst = 1'b0;
        tick(1);
        scan(cnt, col0);
        chk("midrst_count", cnt, 0);

        // Block still life
        toggle_at(20, 20);
        toggle_at(21, 20);
        toggle_at(20, 21);
        toggle_at(21, 21);
        run_step("block1", -1);
        run_step("block2", -1);
        run_step("block3", -1);
        chk("block_gen", {16'd0, gen_count}, 32'd3);
        scan(cnt, col0);
        chk("block_count", cnt, 4);
        chk_cell("block_20_20", 20, 20, 1'b1);
        chk_cell("block_21_21", 21, 21, 1'b1);
        tick(1);

        // clr mid-SCAN: abort, no done, board dead, counter cleared
        mode     = RUN;
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(100);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_busy", {31'd0, busy}, 32'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            tick(1);
        end
        chk("clr_no_done", dones, 0);
        chk("clr_gen", {16'd0, gen_count}, 32'd0);
        scan(cnt, col0);
        chk("clr_count", cnt, 0);
        run_step("empty", -1);
        chk("empty_gen", {16'd0, gen_count}, 32'd1);
        scan(cnt, col0);
        chk("empty_count", cnt, 0);

        // Glider straddling the x edge: origin (62,0), cells (1,0)(2,1)(0,2)(1,2)(2,2)
        toggle_at(63, 0);
        toggle_at(0, 1);
        toggle_at(62, 2);
        toggle_at(63, 2);
        toggle_at(0, 2);
`ifdef BOARD_WRAP_EN
        run_step("glide1", -1);
        run_step("glide2", -1);
        run_step("glide3", -1);
        run_step("glide4", -1);
        chk("glide_gen", {16'd0, gen_count}, 32'd5);
        scan(cnt, col0);
        chk("glide_count", cnt, 5);
        chk_cell("glide_0_1", 0, 1, 1'b1);
        chk_cell("glide_1_2", 1, 2, 1'b1);
        chk_cell("glide_63_3", 63, 3, 1'b1);
        chk_cell("glide_0_3", 0, 3, 1'b1);
        chk_cell("glide_1_3", 1, 3, 1'b1);
`else
        run_step("edge1", -1);
        chk("edge_gen", {16'd0, gen_count}, 32'd2);
        scan(cnt, col0);
        chk("edge_col0", col0, 0);
        chk("edge_count", cnt, 2);
        chk_cell("edge_62_1", 62, 1, 1'b1);
        chk_cell("edge_63_1", 63, 1, 1'b1);
`endif
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
